// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings, FSM states and
// store byte-enable generation.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_e;

    // Unknown funct3 values fall back to a full-word enable.
    function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] a);
        logic [3:0] be;
        case (funct3)
            F3_B, F3_BU: be = 4'b0001 << a;
            F3_H, F3_HU: be = 4'b0011 << {a[1], 1'b0};
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data lane selection and sign/zero extension for the memory-access stage.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr_lo_i)
            2'd0:    lane_b = rdata_i[7:0];
            2'd1:    lane_b = rdata_i[15:8];
            2'd2:    lane_b = rdata_i[23:16];
            default: lane_b = rdata_i[31:24];
        endcase
        lane_h = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        case (funct3_i)
            F3_B:    data_o = {{24{lane_b[7]}}, lane_b};
            F3_BU:   data_o = {24'h0, lane_b};
            F3_H:    data_o = {{16{lane_h[15]}}, lane_h};
            F3_HU:   data_o = {16'h0, lane_h};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: turns load/store ops into req/ack transactions and stalls until done.
// Define MEM_MISALIGN_CHK_EN to flag and suppress misaligned halfword/word accesses.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] ALUout_i,
    input  logic [31:0] wdata_i,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wdata_o,
    output logic [3:0]  dm_be_o,
    input  logic        dm_ack_i,
    input  logic [31:0] dm_rdata_i,
    output logic [31:0] DMdata_o,
    output logic        stall_o,
    output logic        bus_err_o,
    output logic        misalign_o
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             req_q, we_q, berr_q;
    logic [31:0]      addr_q, wdata_q, dmdata_q;
    logic [3:0]       be_q;
    logic [2:0]       f3_q;
    logic [1:0]       alo_q;

    logic        mem_op, misaligned, timeout, start, stall, mis_flag;
    logic [31:0] st_wdata, ld_data;

    assign mem_op  = valid_i & (MemRead_i | MemWrite_i);
    assign timeout = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

`ifdef MEM_MISALIGN_CHK_EN
    always_comb begin
        case (funct3_i)
            F3_B, F3_BU: misaligned = 1'b0;
            F3_H, F3_HU: misaligned = ALUout_i[0];
            default:     misaligned = (ALUout_i[1:0] != 2'b00);
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        case (funct3_i)
            F3_B, F3_BU: st_wdata = {4{wdata_i[7:0]}};
            F3_H, F3_HU: st_wdata = {2{wdata_i[15:0]}};
            default:     st_wdata = wdata_i;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        stall    = 1'b0;
        mis_flag = 1'b0;
        case (state_q)
            StIdle: begin
                if (mem_op) begin
                    if (misaligned) begin
                        mis_flag = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        start   = 1'b1;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                stall = 1'b1;
                if (dm_ack_i || timeout) begin
                    state_d = StDone;
                end
            end
            // The op still presented here was already consumed; never restart from DONE.
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            berr_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            dmdata_q <= '0;
            be_q     <= '0;
            f3_q     <= '0;
            alo_q    <= '0;
        end else begin
            berr_q <= 1'b0;
            if (start) begin
                req_q   <= 1'b1;
                we_q    <= MemWrite_i;
                addr_q  <= {ALUout_i[31:2], 2'b00};
                wdata_q <= st_wdata;
                be_q    <= MemWrite_i ? be_gen(funct3_i, ALUout_i[1:0]) : 4'b1111;
                f3_q    <= funct3_i;
                alo_q   <= ALUout_i[1:0];
                cnt_q   <= '0;
            end else if (mis_flag) begin
                dmdata_q <= '0;
            end else if (state_q == StReq) begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (dm_ack_i) begin
                    req_q <= 1'b0;
                    if (!we_q) begin
                        dmdata_q <= ld_data;
                    end
                end else if (timeout) begin
                    req_q    <= 1'b0;
                    dmdata_q <= '0;
                    berr_q   <= 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    mem_load_ext u_load_ext (
        .funct3_i  (f3_q),
        .addr_lo_i (alo_q),
        .rdata_i   (dm_rdata_i),
        .data_o    (ld_data)
    );

    assign dm_req_o   = req_q;
    assign dm_we_o    = we_q;
    assign dm_addr_o  = addr_q;
    assign dm_wdata_o = wdata_q;
    assign dm_be_o    = be_q;
    assign DMdata_o   = dmdata_q;
    assign bus_err_o  = berr_q;
    // Reset forces the combinational outputs low as well.
    assign stall_o    = stall & rst_i;
    assign misalign_o = mis_flag & rst_i;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed table, random ops against a reference
// model, and hand-written reset / timeout sequences on a short-timeout second instance.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_i, valid_i, MemRead_i, MemWrite_i, dm_ack_i;
    logic [2:0]  funct3_i;
    logic [31:0] ALUout_i, wdata_i, dm_rdata_i;

    logic        dm_req_o, dm_we_o, stall_o, bus_err_o, misalign_o;
    logic [31:0] dm_addr_o, dm_wdata_o, DMdata_o;
    logic [3:0]  dm_be_o;

    logic        t_req, t_we, t_stall, t_berr, t_mis;
    logic [31:0] t_addr, t_wdata, t_dm;
    logic [3:0]  t_be;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_dm;

    always #5 clk = ~clk;

    mem_access_stage u_dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .funct3_i(funct3_i), .ALUout_i(ALUout_i), .wdata_i(wdata_i),
        .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o),
        .dm_be_o(dm_be_o), .dm_ack_i(dm_ack_i), .dm_rdata_i(dm_rdata_i), .DMdata_o(DMdata_o),
        .stall_o(stall_o), .bus_err_o(bus_err_o), .misalign_o(misalign_o)
    );

    mem_access_stage #(.TIMEOUT_CYC(4), .CNT_W(3)) u_dut_to (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .funct3_i(funct3_i), .ALUout_i(ALUout_i), .wdata_i(wdata_i),
        .dm_req_o(t_req), .dm_we_o(t_we), .dm_addr_o(t_addr), .dm_wdata_o(t_wdata),
        .dm_be_o(t_be), .dm_ack_i(dm_ack_i), .dm_rdata_i(dm_rdata_i), .DMdata_o(t_dm),
        .stall_o(t_stall), .bus_err_o(t_berr), .misalign_o(t_mis)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] be_model(input logic wr, input logic [2:0] f3,
                                            input logic [31:0] a);
        int s = size_of(f3);
        if (!wr || s == 4) return 4'hF;
        if (s == 1) return 4'(1 << (a % 4));
        return 4'(3 << (a & 2));
    endfunction

    function automatic logic [31:0] wd_model(input logic [2:0] f3, input logic [31:0] wd);
        int s = size_of(f3);
        if (s == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (s == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: begin
                v = (rd >> (8 * (a % 4))) & 32'hFF;
                if (f3 == 3'b000 && v >= 128) v = v | 32'hFFFF_FF00;
            end
            3'b001, 3'b101: begin
                v = (rd >> (8 * (a & 2))) & 32'hFFFF;
                if (f3 == 3'b001 && v >= 32768) v = v | 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic bit misaligned_model(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHK_EN
        return (a % size_of(f3)) != 0;
`else
        return (f3 == 3'b111) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                          input int dly, input logic [31:0] exp_dm, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd);
        @(posedge clk); #1;
        valid_i = 1'b1; MemRead_i = rd; MemWrite_i = wr; funct3_i = f3;
        ALUout_i = a; wdata_i = wd; dm_ack_i = 1'b0; dm_rdata_i = $urandom;
        @(negedge clk);
        chk("idle_stall", stall_o, 1);
        chk("idle_req", dm_req_o, 0);
        chk("idle_misalign", misalign_o, 0);
        for (int k = 1; k <= dly; k++) begin
            @(posedge clk); #1;
            dm_ack_i   = (k == dly);
            dm_rdata_i = (k == dly) ? rdat : $urandom;
            @(negedge clk);
            chk("req", dm_req_o, 1);
            chk("req_stall", stall_o, 1);
            chk("addr", dm_addr_o, a & ~32'h3);
            chk("we", dm_we_o, wr);
            chk("be", dm_be_o, exp_be);
            if (wr) chk("wdata", dm_wdata_o, exp_wd);
        end
        @(posedge clk); #1;
        dm_ack_i = 1'($urandom % 2);
        dm_rdata_i = $urandom;
        @(negedge clk);
        chk("done_stall", stall_o, 0);
        chk("done_req", dm_req_o, 0);
        chk("done_dmdata", DMdata_o, exp_dm);
        chk("done_berr", bus_err_o, 0);
        @(posedge clk); #1;
        valid_i = 1'b0; dm_ack_i = 1'b0;
        @(negedge clk);
        chk("after_req", dm_req_o, 0);
        chk("after_stall", stall_o, 0);
        chk("after_dmdata", DMdata_o, exp_dm);
        model_dm = exp_dm;
    endtask

    task automatic run_nop();
        @(posedge clk); #1;
        valid_i = 1'($urandom % 2);
        MemRead_i  = valid_i ? 1'b0 : 1'($urandom % 2);
        MemWrite_i = valid_i ? 1'b0 : 1'($urandom % 2);
        funct3_i = 3'($urandom); ALUout_i = $urandom; dm_ack_i = 1'($urandom % 2);
        @(negedge clk);
        chk("nop_stall", stall_o, 0);
        chk("nop_misalign", misalign_o, 0);
        chk("nop_dmdata", DMdata_o, model_dm);
        @(posedge clk); #1;
        valid_i = 1'b0; dm_ack_i = 1'b0;
        @(negedge clk);
        chk("nop_req", dm_req_o, 0);
    endtask

`ifdef MEM_MISALIGN_CHK_EN
    task automatic run_misalign(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        valid_i = 1'b1; MemRead_i = rd; MemWrite_i = wr; funct3_i = f3;
        ALUout_i = a; wdata_i = wd; dm_ack_i = 1'b0;
        @(negedge clk);
        chk("mis_flag", misalign_o, 1);
        chk("mis_stall", stall_o, 0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(negedge clk);
        chk("mis_req", dm_req_o, 0);
        chk("mis_dmdata", DMdata_o, 0);
        model_dm = 32'h0;
    endtask
`endif

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rdat;
        int          dly;
        logic [31:0] exp_dm;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t        tbl[10];
    logic [2:0]  ld_pool[7];
    logic [2:0]  st_pool[3];
    int          kind, dly;
    logic        rdf, wrf;
    logic [2:0]  f3;
    logic [31:0] a, wd, rdat;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 4'hF, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFF7F, 2, 32'hFFFFFF80, 4'hF, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFF7F, 1, 32'h00000080, 4'hF, 32'h0};
        tbl[3] = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FFFF7F, 3, 32'h000080FF, 4'hF, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 3'b000, 32'h201, 32'h12345678, 32'h0, 5, 32'h000080FF, 4'b0010,
                   32'h78787878};
        tbl[5] = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h12348001, 1, 32'hFFFF8001, 4'hF, 32'h0};
        tbl[6] = '{1'b0, 1'b1, 3'b001, 32'h302, 32'hAAAA5555, 32'h0, 2, 32'hFFFF8001, 4'b1100,
                   32'h55555555};
        tbl[7] = '{1'b1, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 1, 32'hFFFF8001, 4'hF,
                   32'hCAFEF00D};
        tbl[8] = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 1, 32'h0000007F, 4'hF, 32'h0};
        tbl[9] = '{1'b1, 1'b0, 3'b111, 32'h10C, 32'h0, 32'h89ABCDEF, 1, 32'h89ABCDEF, 4'hF, 32'h0};
        ld_pool = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
        st_pool = '{3'b000, 3'b001, 3'b010};

        // Reset state with a memory op already presented.
        rst_i = 1'b0; valid_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; funct3_i = 3'b010;
        ALUout_i = 32'h100; wdata_i = 32'h0; dm_ack_i = 1'b1; dm_rdata_i = 32'hFFFF_FFFF;
        #12;
        chk("rst_req", dm_req_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_dmdata", DMdata_o, 0);
        chk("rst_be", dm_be_o, 0);
        chk("rst_berr", bus_err_o, 0);
        valid_i = 1'b0; dm_ack_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        model_dm = 32'h0;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].rdat, tbl[i].dly,
                   tbl[i].exp_dm, tbl[i].exp_be, tbl[i].exp_wd);
        end

`ifdef MEM_MISALIGN_CHK_EN
        run_misalign(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
`else
        run_op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'hA5A50F0F, 1, 32'hA5A50F0F, 4'hF, 32'h0);
`endif

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            a = $urandom; wd = $urandom; rdat = $urandom; dly = $urandom_range(1, 5);
            if (kind == 0) begin
                run_nop();
            end else begin
                rdf = (kind != 2);
                wrf = (kind != 1);
                f3  = wrf ? st_pool[$urandom_range(0, 2)] : ld_pool[$urandom_range(0, 6)];
                if (misaligned_model(f3, a)) begin
`ifdef MEM_MISALIGN_CHK_EN
                    run_misalign(rdf, wrf, f3, a, wd);
`endif
                end else begin
                    run_op(rdf, wrf, f3, a, wd, rdat, dly,
                           wrf ? model_dm : ld_model(f3, a, rdat),
                           be_model(wrf, f3, a), wd_model(f3, wd));
                end
            end
        end

        // Asynchronous reset in the second REQ cycle.
        run_op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0BADF00D, 1, 32'h0BADF00D, 4'hF, 32'h0);
        @(posedge clk); #1;
        valid_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; funct3_i = 3'b010;
        ALUout_i = 32'h240; dm_ack_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_req", dm_req_o, 1);
        #1 rst_i = 1'b0;
        #1;
        chk("mid_rst_req", dm_req_o, 0);
        chk("mid_rst_stall", stall_o, 0);
        chk("mid_rst_dmdata", DMdata_o, 0);
        chk("mid_rst_addr", dm_addr_o, 0);
        chk("mid_rst_we_be", {dm_we_o, dm_be_o}, 0);
        valid_i = 1'b0;
        #1 rst_i = 1'b1;
        model_dm = 32'h0;
        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 4'hF, 32'h0);

        // Short-timeout instance: ack on the terminal-count cycle wins.
        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h13579BDF, 4, 32'h13579BDF, 4'hF, 32'h0);
        chk("to_ack_wins_dm", t_dm, 32'h13579BDF);

        // Short-timeout instance: no ack, abort after four REQ cycles.
        @(posedge clk); #1;
        valid_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; funct3_i = 3'b010;
        ALUout_i = 32'h180; dm_ack_i = 1'b0;
        @(negedge clk);
        chk("to_idle_stall", t_stall, 1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("to_req", t_req, 1);
            chk("to_req_berr", t_berr, 0);
            chk("to_req_stall", t_stall, 1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_done_req", t_req, 0);
        chk("to_done_berr", t_berr, 1);
        chk("to_done_dmdata", t_dm, 0);
        chk("to_done_stall", t_stall, 0);
        @(posedge clk); #1;
        valid_i = 1'b0; dm_ack_i = 1'b1; dm_rdata_i = 32'h7777_7777;
        @(negedge clk);
        chk("to_late_req", t_req, 0);
        chk("to_late_berr", t_berr, 0);
        chk("to_late_dmdata", t_dm, 0);
        @(posedge clk); #1;
        dm_ack_i = 1'b0;
        @(negedge clk);
        chk("to_late_dmdata2", t_dm, 0);
        chk("to_late_stall", t_stall, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
